mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one multi-cycle, single-ported external SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sequences each access with a fixed wait-state count, returns read data in held registers, and drives a pipeline-wide freeze.
- Freeze stays high until every requester active in the current pipeline cycle has been served.
- Sits between the IF/MEM stages and the SRAM pins; the hazard and forwarding logic are untouched.

Parameters:
- ADDR_W, 32, width of the word address forwarded to the SRAM.
- DATA_W, 32, data width.
- WAIT_CYCLES, 4, number of cycles sram_en is held per access; legal range is 1 to 15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  instruction fetch request; held high until the pipeline advances.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered, held until the next IF read.
- if_ready  out  1  one-cycle pulse: if_rdata is valid this cycle.
- mem_rd_req  in  1  data load request.
- mem_wr_req  in  1  data store request.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; registered, held until the next MEM read.
- mem_ready  out  1  one-cycle pulse: load data valid or store complete.
- freeze  out  1  stalls every pipeline register and the PC while high.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable; qualified by sram_en.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid in the last cycle of sram_en.

Behaviour:
- State machine: IDLE, BUSY, RESP. Registers: owner (IF/MEM), a 4-bit wait counter, latched addr/wdata/we, if_done, mem_done.
- Derived pending requests:
  - mem_pend = (mem_rd_req | mem_wr_req) & ~mem_done.
  - if_pend = if_req & ~if_done.
- IDLE:
  - If mem_pend: owner=MEM; latch mem_addr, mem_wdata, we=mem_wr_req.
  - Else if if_pend: owner=IF; latch if_addr, we=0.
  - When either is latched: counter=WAIT_CYCLES-1, go to BUSY.
  - MEM always has priority, since it is the older instruction.
- BUSY:
  - sram_en=1; sram_we/addr/wdata come from the latches.
  - Counter decrements each cycle.
  - When the counter is 0: capture sram_rdata into the owner's rdata register (reads only), go to RESP.
  - Result: BUSY lasts exactly WAIT_CYCLES cycles.
- RESP:
  - Owner's ready=1 for one cycle; set the owner's done flag at the clock edge.
  - Always go to IDLE. No arbitration happens in RESP.
- Latency: request first seen in IDLE at cycle 0 → ready in cycle WAIT_CYCLES+1. A back-to-back second access adds WAIT_CYCLES+2 cycles.
- freeze (combinational) = (mem_pend & ~(RESP & owner==MEM)) | (if_pend & ~(RESP & owner==IF)).
  - It drops in the RESP cycle of the last outstanding requester, so the pipeline advances on that edge.
- Done flags clear at any edge where freeze==0, so the next pipeline cycle's requests are treated as new.
- Request inputs and addresses are sampled only in IDLE. Changes during BUSY/RESP are ignored until the next issue.
- Requests deasserted while not yet served are dropped silently. An in-flight access always completes.
- mem_rd_req & mem_wr_req both high: treated as a write; mem_rdata is unchanged.
- Stores never modify mem_rdata. IF accesses never write.
- Outputs outside BUSY: sram_en=0, sram_we=0; sram_addr/sram_wdata hold their last latched values.
- Reset (including mid-access): state=IDLE, counter=0, owner=IF, both done flags=0, if_rdata=0, mem_rdata=0, ready outputs=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0. The aborted access produces no ready pulse.
  - freeze is combinational: it follows requests immediately after reset.

Test Plan:
- IF only, WAIT_CYCLES=4, if_addr=0x10, sram returns 0xE3A00001 → sram_en high for cycles 1-4, if_ready pulse in cycle 5 with if_rdata=0xE3A00001, freeze high for cycles 0-4 and low in cycle 5.
- Both requests in the same cycle: mem_rd_req addr 0x100 (data 0xAA), if_req addr 0x8 (data 0xBB) → MEM served first (mem_ready in cycle 5, mem_rdata=0xAA, freeze still high), then IF (if_ready in cycle 11, if_rdata=0xBB), freeze low only in cycle 11.
- Store: mem_wr_req addr 0x20, wdata 0x1234 → sram_we=1 with sram_addr=0x20 and sram_wdata=0x1234 for 4 cycles, then mem_ready pulse, mem_rdata unchanged.
- Done-flag clearing: after a combined cycle completes, keep if_req high with a new address → exactly one new fetch is issued, with no duplicate MEM access.
- rst asserted in the 2nd BUSY cycle → next cycle: IDLE, sram_en=0, no ready pulse, rdata=0; a held request then restarts the full WAIT_CYCLES access.
- mem_rd_req & mem_wr_req both high → write is performed, mem_rdata unchanged; with WAIT_CYCLES=1, ready arrives 2 cycles after the request is sampled.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported wait-state SRAM between the IF and MEM requesters
//
// Purpose:
//   Serialises instruction fetches and data loads/stores onto one multi-cycle
//   SRAM port and raises a pipeline-wide freeze until every requester active in
//   the current pipeline cycle has been served. MEM wins arbitration because
//   it belongs to the older instruction.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address (held until pipeline advances)
//   if_rdata/if_ready         registered fetch data, one-cycle valid pulse
//   mem_rd_req/mem_wr_req     data load/store requests
//   mem_addr/mem_wdata        data address and store data
//   mem_rdata/mem_ready       registered load data, one-cycle done pulse
//   freeze                    stalls all pipeline registers and the PC
//   sram_en/sram_we           SRAM enable and write enable (we qualified by en)
//   sram_addr/sram_wdata      SRAM address and write data (hold last latched values)
//   sram_rdata                SRAM read data, valid in the last sram_en cycle

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_MEM  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic mem_pend;
  logic if_pend;
  logic resp_if;
  logic resp_mem;

  assign mem_pend = (mem_rd_req | mem_wr_req) & ~mem_done_q;
  assign if_pend  = if_req & ~if_done_q;
  assign resp_if  = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign resp_mem = (state_q == S_RESP) && (owner_q == OWN_MEM);

  // A requester being answered this cycle no longer holds the pipeline, so
  // freeze drops in the RESP cycle of the last outstanding requester.
  assign freeze = (mem_pend & ~resp_mem) | (if_pend & ~resp_if);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_pend) begin
          owner_d = OWN_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          // Read and write together is treated as a write.
          we_d    = mem_wr_req;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end else if (if_pend) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWN_MEM) mem_rdata_d = sram_rdata;
            else                    if_rdata_d  = sram_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (owner_q == OWN_MEM) mem_done_d = 1'b1;
        else                    if_done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The pipeline advances on any edge without freeze; the next pipeline
    // cycle's requests must then be seen as new.
    if (!freeze) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_ready   = resp_if;
  assign mem_ready  = resp_mem;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_en    = (state_q == S_BUSY);
  assign sram_we    = (state_q == S_BUSY) & we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, mem_rd_req, mem_wr_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, freeze, sram_en, sram_we;

  logic        w1_if_req, w1_mem_rd_req, w1_mem_wr_req;
  logic [31:0] w1_if_addr, w1_mem_addr, w1_mem_wdata;
  logic [31:0] w1_if_rdata, w1_mem_rdata, w1_sram_addr, w1_sram_wdata, w1_sram_rdata;
  logic        w1_if_ready, w1_mem_ready, w1_freeze, w1_sram_en, w1_sram_we;

  logic [31:0] mem0 [0:511];

  always #5 clk = ~clk;

  assign sram_rdata    = mem0[sram_addr[8:0]];
  assign w1_sram_rdata = 32'hC0DE_0000 ^ w1_sram_addr;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .if_req(w1_if_req), .if_addr(w1_if_addr), .if_rdata(w1_if_rdata), .if_ready(w1_if_ready),
    .mem_rd_req(w1_mem_rd_req), .mem_wr_req(w1_mem_wr_req), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
    .freeze(w1_freeze), .sram_en(w1_sram_en), .sram_we(w1_sram_we), .sram_addr(w1_sram_addr),
    .sram_wdata(w1_sram_wdata), .sram_rdata(w1_sram_rdata)
  );

  typedef struct {
    logic        is_mem;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] en_tr, we_tr, fr_tr, ifr_tr, memr_tr;
  logic [31:0] w1en_tr, w1we_tr, w1r_tr;
  logic [31:0] addr_tr [0:31];
  logic [31:0] wd_tr   [0:31];
  logic [31:0] if_rd0, mem_rd0;
  int          w1_rd_bad;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic is_mem, input logic [31:0] data);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic is_mem, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check(is_mem ? "unexpected_mem_ready" : "unexpected_if_ready", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("ready_order", {63'd0, is_mem}, {63'd0, e.is_mem});
      check(is_mem ? "mem_rdata" : "if_rdata", {32'd0, data}, {32'd0, e.data});
    end
  endtask

  // Records n cycles of activity, sampling on the falling edge, and feeds
  // every ready pulse through the scoreboard.
  task automatic run(input int n);
    en_tr = '0; we_tr = '0; fr_tr = '0; ifr_tr = '0; memr_tr = '0;
    w1en_tr = '0; w1we_tr = '0; w1r_tr = '0; w1_rd_bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_tr[i]   = sram_en;
      we_tr[i]   = sram_we;
      fr_tr[i]   = freeze;
      ifr_tr[i]  = if_ready;
      memr_tr[i] = mem_ready;
      addr_tr[i] = sram_addr;
      wd_tr[i]   = sram_wdata;
      w1en_tr[i] = w1_sram_en;
      w1we_tr[i] = w1_sram_we;
      w1r_tr[i]  = w1_mem_ready;
      if (w1_mem_rdata !== 32'd0) w1_rd_bad++;
      if (i == 0) begin
        if_rd0  = if_rdata;
        mem_rd0 = mem_rdata;
      end
      if (if_ready)  sb_pop(1'b0, if_rdata);
      if (mem_ready) sb_pop(1'b1, mem_rdata);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem0[i] = 32'hF000_0000 | i;
    mem0[9'h010] = 32'hE3A0_0001;
    mem0[9'h100] = 32'h0000_00AA;
    mem0[9'h008] = 32'h0000_00BB;
    mem0[9'h00C] = 32'h0000_00CC;

    rst = 1'b1;
    if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    w1_if_req = 0; w1_mem_rd_req = 0; w1_mem_wr_req = 0;
    w1_if_addr = 0; w1_mem_addr = 0; w1_mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_freeze", {63'd0, freeze}, 64'd0);
    check("rst_sram_en", {63'd0, sram_en}, 64'd0);
    check("rst_ready", {62'd0, if_ready, mem_ready}, 64'd0);
    check("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
    check("rst_sram_addr", {sram_addr, sram_wdata}, 64'd0);
    @(posedge clk);
    #1;

    // IF only
    if_req = 1; if_addr = 32'h10;
    push(1'b0, 32'hE3A0_0001);
    run(6);
    if_req = 0;
    check("t1_sram_en", {32'd0, en_tr}, 64'h1E);
    check("t1_freeze", {32'd0, fr_tr}, 64'h1F);
    check("t1_if_ready", {32'd0, ifr_tr}, 64'h20);
    check("t1_no_write", {32'd0, we_tr | memr_tr}, 64'd0);
    check("t1_addr", {32'd0, addr_tr[1]}, 64'h10);

    // MEM and IF in the same pipeline cycle
    mem_rd_req = 1; mem_addr = 32'h100;
    if_req = 1; if_addr = 32'h8;
    push(1'b1, 32'hAA);
    push(1'b0, 32'hBB);
    run(12);
    check("t2_sram_en", {32'd0, en_tr}, 64'h79E);
    check("t2_freeze", {32'd0, fr_tr}, 64'h7FF);
    check("t2_mem_ready", {32'd0, memr_tr}, 64'h20);
    check("t2_if_ready", {32'd0, ifr_tr}, 64'h800);
    check("t2_addr_mem", {32'd0, addr_tr[1]}, 64'h100);
    check("t2_addr_if", {32'd0, addr_tr[7]}, 64'h8);

    // Next pipeline cycle: only a new fetch, no duplicate MEM access
    mem_rd_req = 0; if_addr = 32'hC;
    push(1'b0, 32'hCC);
    run(6);
    if_req = 0;
    check("t3_sram_en", {32'd0, en_tr}, 64'h1E);
    check("t3_if_ready", {32'd0, ifr_tr}, 64'h20);
    check("t3_no_mem", {32'd0, memr_tr}, 64'd0);
    check("t3_addr", {32'd0, addr_tr[1]}, 64'hC);
    run(3);
    check("t3_quiet", {32'd0, en_tr | ifr_tr | memr_tr}, 64'd0);

    // Store leaves mem_rdata untouched
    mem_wr_req = 1; mem_addr = 32'h20; mem_wdata = 32'h1234;
    push(1'b1, 32'hAA);
    run(6);
    mem_wr_req = 0;
    check("t4_sram_en", {32'd0, en_tr}, 64'h1E);
    check("t4_sram_we", {32'd0, we_tr}, 64'h1E);
    check("t4_mem_ready", {32'd0, memr_tr}, 64'h20);
    check("t4_addr", {32'd0, addr_tr[2]}, 64'h20);
    check("t4_wdata", {32'd0, wd_tr[4]}, 64'h1234);

    // Reset during the second BUSY cycle, then the held request restarts
    if_req = 1; if_addr = 32'h10;
    run(2);
    rst = 1;
    run(1);
    check("t5_busy_at_rst", {32'd0, en_tr}, 64'h1);
    rst = 0;
    push(1'b0, 32'hE3A0_0001);
    run(6);
    if_req = 0;
    check("t5_rdata_cleared", {if_rd0, mem_rd0}, 64'd0);
    check("t5_sram_en", {32'd0, en_tr}, 64'h1E);
    check("t5_if_ready", {32'd0, ifr_tr}, 64'h20);
    check("t5_freeze", {32'd0, fr_tr}, 64'h1F);

    // Read and write together with WAIT_CYCLES=1
    w1_mem_rd_req = 1; w1_mem_wr_req = 1; w1_mem_addr = 32'h30; w1_mem_wdata = 32'h55;
    run(3);
    w1_mem_rd_req = 0; w1_mem_wr_req = 0;
    check("t6_sram_en", {32'd0, w1en_tr}, 64'h2);
    check("t6_sram_we", {32'd0, w1we_tr}, 64'h2);
    check("t6_mem_ready", {32'd0, w1r_tr}, 64'h4);
    check("t6_rdata_kept", w1_rd_bad, 64'd0);
    run(2);
    check("t6_quiet", {32'd0, w1en_tr | w1r_tr}, 64'd0);
    check("t6_hold", {w1_sram_addr, w1_sram_wdata}, {32'h30, 32'h55});
    check("hold_addr", {31'd0, sram_we, sram_addr}, 64'h10);

    check("sb_empty", sb.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
